// File: rtl/lcd_bus_pkg.sv
// Shared opcodes, decoder states and helper types for the LCD bus receiver.
package lcd_bus_pkg;

    // ILI9341 opcodes that the receiver acts on
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    // Command decoder state
    typedef enum logic [2:0] {
        IDLE,
        CASET,
        PASET,
        RAMWR,
        SKIP
    } state_e;

    // Position within the four-byte CASET/PASET parameter sequence
    typedef logic [1:0] param_idx_t;

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous 8080 bus pins into the clk domain.
// It detects the rising edge of lcd_wr and emits a one-cycle write event
// carrying the data/dc that were sampled in the same synchronizer stage.
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] lcd_data_i,
    input  logic        lcd_dc_i,
    input  logic        lcd_wr_i,
    input  logic        lcd_rd_i,
    input  logic        lcd_reset_n_i,
    output logic        ev_valid_o,
    output logic [15:0] ev_data_o,
    output logic        ev_dc_o,
    output logic        bus_err_o,
    output logic        panel_rst_o
);

    // Bit layout of one synchronizer stage: {reset_n, rd, wr, dc, data}
    localparam int          BUS_W    = 20;
    // Strobes and panel reset idle high, so they reset high to avoid a false edge
    localparam logic [19:0] SYNC_RST = 20'hE0000;

    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic [BUS_W-1:0] stage;
    logic             wr_s;
    logic             rd_s;
    logic             wr_prev_q;
    logic             coll_q;
    logic             ev_valid_q;
    logic [15:0]      ev_data_q;
    logic             ev_dc_q;
    logic             bus_err_q;
    logic             wr_rise;
    logic             overlap;

    assign stage   = sync_q[SYNC_STAGES-1];
    assign wr_s    = stage[17];
    assign rd_s    = stage[18];
    assign wr_rise = wr_s && !wr_prev_q;
    assign overlap = !wr_s && !rd_s;

    // Shift every bus pin through the synchronizer chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RST;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous
            // stage's old value, which is what turns this loop into a shift chain.
            sync_q[0] <= {lcd_reset_n_i, lcd_rd_i, lcd_wr_i, lcd_dc_i, lcd_data_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Detect the write edge, drop strobes that overlapped a read, register the event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_prev_q  <= 1'b1;
            coll_q     <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_data_q  <= '0;
            ev_dc_q    <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            wr_prev_q  <= wr_s;
            ev_valid_q <= wr_rise && !coll_q;
            ev_data_q  <= stage[15:0];
            ev_dc_q    <= stage[16];
            bus_err_q  <= overlap;
            if (wr_rise) begin
                coll_q <= 1'b0;
            end else if (overlap) begin
                coll_q <= 1'b1;
            end
        end
    end

    assign ev_valid_o  = ev_valid_q;
    assign ev_data_o   = ev_data_q;
    assign ev_dc_o     = ev_dc_q;
    assign bus_err_o   = bus_err_q;
    assign panel_rst_o = !stage[19];

endmodule

// File: rtl/lcd_bus_receiver.sv
// Responder end of an 8080-style LCD bus: decodes the ILI9341 command stream,
// tracks the column/page window and emits a coordinate-tagged pixel stream.
module lcd_bus_receiver
    import lcd_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int COORD_W     = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        lcd_data,
    input  logic               lcd_dc,
    input  logic               lcd_wr,
    input  logic               lcd_rd,
    input  logic               lcd_reset_n,
    input  logic               err_clear,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_data,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               frame_done,
    output logic               protocol_err
);

    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(HEIGHT - 1);
    localparam logic [15:0]        WIDTH_16  = 16'(WIDTH);
    localparam logic [15:0]        HEIGHT_16 = 16'(HEIGHT);

    logic         ev_valid;
    logic [15:0]  ev_data;
    logic         ev_dc;
    logic         bus_err;
    logic         panel_rst;

    state_e             state_q;
    param_idx_t         idx_q;
    logic [7:0]         sh_start_hi_q;
    logic [7:0]         sh_start_lo_q;
    logic [7:0]         sh_end_hi_q;
    logic [COORD_W-1:0] sc_q, ec_q, sp_q, ep_q;
    logic [COORD_W-1:0] cur_x_q, cur_y_q;
    logic [COORD_W-1:0] cur_x_d, cur_y_d;
    logic               pix_valid_q;
    logic [COORD_W-1:0] pix_x_q, pix_y_q;
    logic [15:0]        pix_data_q;
    logic               cmd_valid_q;
    logic [7:0]         cmd_code_q;
    logic               frame_done_q;
    logic               protocol_err_q;

    logic [15:0] start_val;
    logic [15:0] end_val;
    logic [15:0] limit;
    logic        commit_ok;
    logic        window_write;
    logic        reject;
    logic        at_ec;
    logic        last_pixel;

    lcd_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .reset        (reset),
        .lcd_data_i   (lcd_data),
        .lcd_dc_i     (lcd_dc),
        .lcd_wr_i     (lcd_wr),
        .lcd_rd_i     (lcd_rd),
        .lcd_reset_n_i(lcd_reset_n),
        .ev_valid_o   (ev_valid),
        .ev_data_o    (ev_data),
        .ev_dc_o      (ev_dc),
        .bus_err_o    (bus_err),
        .panel_rst_o  (panel_rst)
    );

    // Window commit check and cursor advance for the current event
    always_comb begin
        // NOTE: every signal here is assigned on every path through the block,
        // so no latch can be inferred.
        start_val    = {sh_start_hi_q, sh_start_lo_q};
        end_val      = {sh_end_hi_q, ev_data[7:0]};
        limit        = (state_q == CASET) ? WIDTH_16 : HEIGHT_16;
        commit_ok    = (start_val <= end_val) && (end_val < limit);
        window_write = ev_valid && !panel_rst && ev_dc && (idx_q == 2'd3)
                       && ((state_q == CASET) || (state_q == PASET));
        reject       = window_write && !commit_ok;
        at_ec        = (cur_x_q == ec_q);
        last_pixel   = at_ec && (cur_y_q == ep_q);
        cur_x_d      = at_ec ? sc_q : cur_x_q + COORD_W'(1);
        cur_y_d      = !at_ec   ? cur_y_q :
                       last_pixel ? sp_q : cur_y_q + COORD_W'(1);
    end

    // Command decoder, window registers, cursor and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            sh_start_hi_q  <= '0;
            sh_start_lo_q  <= '0;
            sh_end_hi_q    <= '0;
            sc_q           <= '0;
            ec_q           <= X_LAST;
            sp_q           <= '0;
            ep_q           <= Y_LAST;
            cur_x_q        <= '0;
            cur_y_q        <= '0;
            pix_valid_q    <= 1'b0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            pix_data_q     <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_code_q     <= '0;
            frame_done_q   <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            pix_valid_q  <= 1'b0;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;

            // A new error in the same cycle as err_clear keeps the flag set
            if (bus_err || reject) begin
                protocol_err_q <= 1'b1;
            end else if (err_clear) begin
                protocol_err_q <= 1'b0;
            end

            if (panel_rst) begin
                state_q <= IDLE;
                idx_q   <= '0;
                sc_q    <= '0;
                ec_q    <= X_LAST;
                sp_q    <= '0;
                ep_q    <= Y_LAST;
                cur_x_q <= '0;
                cur_y_q <= '0;
            end else if (ev_valid && !ev_dc) begin
                cmd_valid_q <= 1'b1;
                cmd_code_q  <= ev_data[7:0];
                idx_q       <= '0;
                case (ev_data[7:0])
                    CMD_CASET:  state_q <= CASET;
                    CMD_PASET:  state_q <= PASET;
                    CMD_RAMWR: begin
                        state_q <= RAMWR;
                        cur_x_q <= sc_q;
                        cur_y_q <= sp_q;
                    end
                    CMD_RAMWRC: state_q <= RAMWR;
                    CMD_SWRESET: begin
                        state_q <= IDLE;
                        sc_q    <= '0;
                        ec_q    <= X_LAST;
                        sp_q    <= '0;
                        ep_q    <= Y_LAST;
                    end
                    default:    state_q <= SKIP;
                endcase
            end else if (ev_valid) begin
                case (state_q)
                    CASET, PASET: begin
                        idx_q <= idx_q + 2'd1;
                        case (idx_q)
                            2'd0: sh_start_hi_q <= ev_data[7:0];
                            2'd1: sh_start_lo_q <= ev_data[7:0];
                            2'd2: sh_end_hi_q   <= ev_data[7:0];
                            default: begin
                                state_q <= IDLE;
                                if (commit_ok && (state_q == CASET)) begin
                                    sc_q <= start_val[COORD_W-1:0];
                                    ec_q <= end_val[COORD_W-1:0];
                                end else if (commit_ok) begin
                                    sp_q <= start_val[COORD_W-1:0];
                                    ep_q <= end_val[COORD_W-1:0];
                                end
                            end
                        endcase
                    end
                    RAMWR: begin
                        pix_valid_q  <= 1'b1;
                        pix_x_q      <= cur_x_q;
                        pix_y_q      <= cur_y_q;
                        pix_data_q   <= ev_data;
                        frame_done_q <= last_pixel;
                        cur_x_q      <= cur_x_d;
                        cur_y_q      <= cur_y_d;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pix_valid    = pix_valid_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_data     = pix_data_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_code     = cmd_code_q;
    assign frame_done   = frame_done_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver. The panel is shrunk to 24x32 so a
// full-window frame stays short; all window/cursor rules are size independent.
module tb_lcd_bus_receiver;

    localparam int W  = 24;
    localparam int H  = 32;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   lcd_data;
    logic          lcd_dc;
    logic          lcd_wr;
    logic          lcd_rd;
    logic          lcd_reset_n;
    logic          err_clear;
    logic          pix_valid;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [15:0]   pix_data;
    logic          cmd_valid;
    logic [7:0]    cmd_code;
    logic          frame_done;
    logic          protocol_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [15:0]   d;
        logic          fd;
    } pix_t;

    pix_t       pix_q[$];
    logic [7:0] cmd_q[$];
    int         fd_cnt = 0;
    pix_t       mon_p;

    lcd_bus_receiver #(
        .SYNC_STAGES(2),
        .WIDTH      (W),
        .HEIGHT     (H),
        .COORD_W    (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_data    (lcd_data),
        .lcd_dc      (lcd_dc),
        .lcd_wr      (lcd_wr),
        .lcd_rd      (lcd_rd),
        .lcd_reset_n (lcd_reset_n),
        .err_clear   (err_clear),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .frame_done  (frame_done),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Record every output pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (pix_valid) begin
            mon_p.x  = pix_x;
            mon_p.y  = pix_y;
            mon_p.d  = pix_data;
            mon_p.fd = frame_done;
            pix_q.push_back(mon_p);
        end
        if (cmd_valid) cmd_q.push_back(cmd_code);
        if (frame_done) fd_cnt++;
    end

    // One bus write: wr low 4 clk, then high 6 clk so the event has landed on return
    task automatic bus_write(input logic dc, input logic [15:0] d);
        @(negedge clk);
        lcd_dc   = dc;
        lcd_data = d;
        lcd_wr   = 1'b0;
        repeat (4) @(negedge clk);
        lcd_wr = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic window_cmd(input logic [7:0] op, input logic [15:0] s, input logic [15:0] e);
        bus_write(1'b0, {8'h00, op});
        bus_write(1'b1, {8'h00, s[15:8]});
        bus_write(1'b1, {8'h00, s[7:0]});
        bus_write(1'b1, {8'h00, e[15:8]});
        bus_write(1'b1, {8'h00, e[7:0]});
    endtask

    task automatic pulse_err_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lcd_data = '0; lcd_dc = 1'b0; lcd_wr = 1'b1; lcd_rd = 1'b1;
        lcd_reset_n = 1'b1; err_clear = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({pix_valid, pix_x, pix_y, pix_data} !== '0) begin
            bad++; $display("FAIL reset_pix: got v=%b x=%0d y=%0d d=%h want all 0",
                            pix_valid, pix_x, pix_y, pix_data);
        end
        total++;
        if ({cmd_valid, cmd_code, frame_done, protocol_err} !== '0) begin
            bad++; $display("FAIL reset_ctrl: got cv=%b cc=%h fd=%b err=%b want all 0",
                            cmd_valid, cmd_code, frame_done, protocol_err);
        end
        reset = 1'b0;
        repeat (100) @(negedge clk);
        total++;
        if (pix_q.size() + cmd_q.size() + fd_cnt !== 0) begin
            bad++; $display("FAIL idle_quiet: got pix=%0d cmd=%0d fd=%0d want 0 0 0",
                            pix_q.size(), cmd_q.size(), fd_cnt);
        end
    endtask

    task automatic test_window_stream();
        int   xs [7] = '{10, 11, 12, 10, 11, 12, 10};
        int   ys [7] = '{5, 5, 5, 6, 6, 6, 5};
        logic fds[7] = '{0, 0, 0, 0, 0, 1, 0};
        logic [7:0] exp_cmd[3] = '{8'h2A, 8'h2B, 8'h2C};
        pix_t p;
        logic [7:0] c;
        window_cmd(8'h2A, 16'h000A, 16'h000C);
        window_cmd(8'h2B, 16'h0005, 16'h0006);
        bus_write(1'b0, 16'h002C);
        for (int i = 0; i < 7; i++) bus_write(1'b1, 16'hF800 + 16'(i));
        total++;
        if (cmd_q.size() !== 3) begin
            bad++; $display("FAIL stream_cmd_count: got %0d want 3", cmd_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                c = cmd_q.pop_front();
                total++;
                if (c !== exp_cmd[i]) begin
                    bad++; $display("FAIL stream_cmd_code[%0d]: got %h want %h", i, c, exp_cmd[i]);
                end
            end
        end
        total++;
        if (pix_q.size() !== 7) begin
            bad++; $display("FAIL stream_pix_count: got %0d want 7", pix_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                p = pix_q.pop_front();
                total++;
                if (p.x !== CW'(xs[i]) || p.y !== CW'(ys[i]) ||
                    p.d !== 16'hF800 + 16'(i) || p.fd !== fds[i]) begin
                    bad++; $display("FAIL stream_pix[%0d]: got (%0d,%0d) %h fd=%b want (%0d,%0d) %h fd=%b",
                                    i, p.x, p.y, p.d, p.fd, xs[i], ys[i], 16'hF800 + 16'(i), fds[i]);
                end
            end
        end
        cmd_q.delete();
    endtask

    task automatic test_caset_reject();
        pix_t p;
        window_cmd(8'h2A, 16'h0020, 16'h0010);
        total++;
        if (protocol_err !== 1'b1) begin
            bad++; $display("FAIL caset_start_gt_end_err: got %b want 1", protocol_err);
        end
        // Aborted update: command after two parameter bytes
        bus_write(1'b0, 16'h002A);
        bus_write(1'b1, 16'h0000);
        bus_write(1'b1, 16'h0000);
        bus_write(1'b0, 16'h002C);
        bus_write(1'b1, 16'hAAAA);
        total++;
        if (pix_q.size() !== 1) begin
            bad++; $display("FAIL reject_pix_count: got %0d want 1", pix_q.size());
        end else begin
            p = pix_q.pop_front();
            total++;
            if (p.x !== CW'(10) || p.y !== CW'(5) || p.d !== 16'hAAAA) begin
                bad++; $display("FAIL reject_window_kept: got (%0d,%0d) %h want (10,5) aaaa", p.x, p.y, p.d);
            end
        end
        pulse_err_clear();
        total++;
        if (protocol_err !== 1'b0) begin
            bad++; $display("FAIL err_clear: got %b want 0", protocol_err);
        end
        // End equal to WIDTH is one past the last column
        window_cmd(8'h2A, 16'h000A, 16'(W));
        total++;
        if (protocol_err !== 1'b1) begin
            bad++; $display("FAIL caset_end_eq_width_err: got %b want 1", protocol_err);
        end
        pulse_err_clear();
        pix_q.delete();
        cmd_q.delete();
    endtask

    task automatic test_skip_continue();
        int   xs[3] = '{10, 11, 12};
        pix_t p;
        bus_write(1'b0, 16'h002C);
        bus_write(1'b1, 16'h1000);
        bus_write(1'b1, 16'h1001);
        bus_write(1'b0, 16'h0000);
        bus_write(1'b1, 16'h1002);
        bus_write(1'b0, 16'h003C);
        bus_write(1'b1, 16'h1003);
        total++;
        if (pix_q.size() !== 3) begin
            bad++; $display("FAIL skip_pix_count: got %0d want 3", pix_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                p = pix_q.pop_front();
                total++;
                if (p.x !== CW'(xs[i]) || p.y !== CW'(5) ||
                    p.d !== ((i == 2) ? 16'h1003 : 16'h1000 + 16'(i))) begin
                    bad++; $display("FAIL skip_continue_pix[%0d]: got (%0d,%0d) %h want (%0d,5)",
                                    i, p.x, p.y, p.d, xs[i]);
                end
            end
        end
        cmd_q.delete();
    endtask

    task automatic test_panel_reset();
        @(negedge clk);
        lcd_reset_n = 1'b0;
        repeat (10) @(negedge clk);
        lcd_reset_n = 1'b1;
        repeat (5) @(negedge clk);
        bus_write(1'b1, 16'h2222);
        bus_write(1'b1, 16'h3333);
        total++;
        if (pix_q.size() !== 0) begin
            bad++; $display("FAIL panel_reset_no_resume: got %0d pixels want 0", pix_q.size());
        end
        pix_q.delete();
    endtask

    task automatic test_full_frame();
        pix_t p;
        int   n_bad = 0;
        // Boundary windows that equal the full screen are accepted
        window_cmd(8'h2A, 16'h0000, 16'(W - 1));
        window_cmd(8'h2B, 16'h0000, 16'(H - 1));
        total++;
        if (protocol_err !== 1'b0) begin
            bad++; $display("FAIL full_window_accept: got err=%b want 0", protocol_err);
        end
        bus_write(1'b0, 16'h002C);
        fd_cnt = 0;
        for (int i = 0; i < W * H; i++) bus_write(1'b1, 16'(i));
        total++;
        if (pix_q.size() !== W * H) begin
            bad++; $display("FAIL frame_pix_count: got %0d want %0d", pix_q.size(), W * H);
        end else begin
            for (int i = 0; i < W * H; i++) begin
                p = pix_q.pop_front();
                total++;
                if (p.x !== CW'(i % W) || p.y !== CW'(i / W) || p.d !== 16'(i) ||
                    p.fd !== (i == W * H - 1)) begin
                    bad++; n_bad++;
                    if (n_bad <= 8)
                        $display("FAIL frame_pix[%0d]: got (%0d,%0d) %h fd=%b want (%0d,%0d) %h",
                                 i, p.x, p.y, p.d, p.fd, i % W, i / W, 16'(i));
                end
            end
        end
        total++;
        if (fd_cnt !== 1) begin
            bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt);
        end
        cmd_q.delete();
    endtask

    task automatic test_collision();
        pix_t p;
        total++;
        if (protocol_err !== 1'b0) begin
            bad++; $display("FAIL collision_pre_err: got %b want 0", protocol_err);
        end
        @(negedge clk);
        lcd_dc = 1'b1; lcd_data = 16'h1234; lcd_rd = 1'b0; lcd_wr = 1'b0;
        repeat (5) @(negedge clk);
        lcd_rd = 1'b1; lcd_wr = 1'b1;
        repeat (6) @(negedge clk);
        lcd_dc = 1'b0; lcd_data = 16'h002C; lcd_rd = 1'b0; lcd_wr = 1'b0;
        repeat (5) @(negedge clk);
        lcd_rd = 1'b1; lcd_wr = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (protocol_err !== 1'b1) begin
            bad++; $display("FAIL collision_err: got %b want 1", protocol_err);
        end
        total++;
        if (pix_q.size() + cmd_q.size() !== 0) begin
            bad++; $display("FAIL collision_suppressed: got pix=%0d cmd=%0d want 0 0",
                            pix_q.size(), cmd_q.size());
        end
        // Cursor wrapped after the full frame, so the next good write is at (0,0)
        bus_write(1'b1, 16'h5A5A);
        total++;
        if (pix_q.size() !== 1) begin
            bad++; $display("FAIL after_collision_count: got %0d want 1", pix_q.size());
        end else begin
            p = pix_q.pop_front();
            total++;
            if (p.x !== '0 || p.y !== '0 || p.d !== 16'h5A5A) begin
                bad++; $display("FAIL after_collision_pix: got (%0d,%0d) %h want (0,0) 5a5a", p.x, p.y, p.d);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (pix_data !== 16'h0000 || protocol_err !== 1'b0 || cmd_code !== 8'h00) begin
            bad++; $display("FAIL async_reset: got d=%h err=%b cc=%h want 0000 0 00",
                            pix_data, protocol_err, cmd_code);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_window_stream();
        test_caset_reject();
        test_skip_continue();
        test_panel_reset();
        test_full_frame();
        test_collision();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Responder end of the LCD controller's 8080-style parallel bus: lcd_data[15:0], lcd_dc, lcd_wr, lcd_rd, lcd_reset_n.
- Oversamples the bus on the system clock and decodes the ILI9341 command/parameter stream.
- Tracks the column/page address window and emits a pixel stream tagged with (x, y) coordinates.
- Used as a synthesizable panel model and as an on-chip bus monitor for checking the LCD controller.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for every bus input.
- WIDTH, 240, panel columns.
- HEIGHT, 320, panel rows.
- COORD_W, 9, coordinate width; must satisfy 2^COORD_W >= max(WIDTH, HEIGHT).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- lcd_data  in  16  bus data.
- lcd_dc  in  1  0 = command, 1 = data/parameter.
- lcd_wr  in  1  write strobe, active low; data is latched on the rising edge.
- lcd_rd  in  1  read strobe, active low; reads are not serviced.
- lcd_reset_n  in  1  panel hard reset, active low.
- err_clear  in  1  one-cycle pulse; clears protocol_err.
- pix_valid  out  1  one-cycle pulse per pixel write.
- pix_x  out  COORD_W  pixel column.
- pix_y  out  COORD_W  pixel row.
- pix_data  out  16  RGB565 pixel value.
- cmd_valid  out  1  one-cycle pulse per command byte.
- cmd_code  out  8  command opcode.
- frame_done  out  1  pulse coincident with the last pixel of the window.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset state: all outputs 0, state IDLE, window = full screen (SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1), cursor = (0,0).
- Input sampling:
  - All bus inputs pass through SYNC_STAGES flops.
  - A write event is the synchronized lcd_wr 0->1 edge; data and dc are taken from the same synchronized stage.
  - lcd_wr low and high phases must each be >= SYNC_STAGES+1 clk.
- Latency: outputs are registered and appear SYNC_STAGES+2 clk after the pin edge. pix_*/cmd_code hold until the next event.
- Command event (dc=0):
  - Pulse cmd_valid with cmd_code = data[7:0].
  - 0x2A -> CASET; 0x2B -> PASET; 0x2C -> RAMWR with cursor = (SC, SP).
  - 0x3C -> RAMWR, cursor unchanged (continue).
  - 0x01 -> soft reset: window full screen, state IDLE.
  - Any other opcode -> SKIP. Any command terminates RAMWR.
- CASET/PASET:
  - Four data bytes, in order: start hi, start lo, end hi, end lo (data[7:0] used).
  - Values go to a shadow register, committed on the 4th byte; state then returns to IDLE.
  - Commit is rejected if start > end or end >= WIDTH (CASET) / HEIGHT (PASET). On rejection: protocol_err=1, window unchanged.
  - A command arriving before the 4th byte aborts the update and leaves the window unchanged.
- RAMWR data event:
  - Pulse pix_valid with the current cursor and data.
  - Advance cursor: if x==EC then x=SC and y advances, else x+1.
  - If x==EC and y==EP: pulse frame_done with this pixel and wrap the cursor to (SC, SP).
- SKIP/IDLE data events: ignored, no outputs.
- Error conditions:
  - Synchronized lcd_rd low while lcd_wr low -> protocol_err=1.
  - lcd_rd alone is ignored.
  - err_clear clears protocol_err; if a new error arises in the same cycle, the set wins.
- lcd_reset_n low (synchronized):
  - State IDLE, window full screen, cursor (0,0), write events ignored.
  - pix_valid/cmd_valid/frame_done forced 0; protocol_err retained.
  - Resumes on release; an interrupted RAMWR is not resumed until a new 0x2C/0x3C.
- reset mid-operation: immediate return to reset state.

Decomposition:
- Package lcd_bus_pkg:
  - opcode constants: CMD_SWRESET 0x01, CMD_CASET 0x2A, CMD_PASET 0x2B, CMD_RAMWR 0x2C, CMD_RAMWRC 0x3C;
  - state enum {IDLE, CASET, PASET, RAMWR, SKIP};
  - parameter-index type 0..3.
- Sub-module lcd_bus_sync: SYNC_STAGES synchronizer for all inputs, lcd_wr rising-edge detector, and output of a write-event pulse with aligned data/dc.

Test Plan:
- Reset, then idle bus at lcd_wr=1 -> all outputs 0, no pulses for 100 clk.
- Cmd 0x2A with 00,0A,00,0C; cmd 0x2B with 00,05,00,06; cmd 0x2C; then 6 words 0xF800..0xF805:
  - pix at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6);
  - frame_done only with the 6th;
  - a 7th word lands at (10,5).
- Cmd 0x2A with 00,20,00,10 -> protocol_err=1; subsequent 0x2C write lands at the previous SC. err_clear -> protocol_err=0.
- In RAMWR after 2 pixels at (10,5),(11,5): cmd 0x00, then 0x3C, then a word -> pix at (12,5); a word sent after 0x00 alone -> no pix_valid.
- lcd_reset_n low for 10 clk mid-RAMWR, then release, then data words -> no pix_valid. After 0x2C the first pix is at (0,0); full window 0..239 x 0..319 gives frame_done on pixel 76800.
- lcd_rd and lcd_wr held low together for 5 clk -> protocol_err=1, no cmd_valid/pix_valid from that cycle.
